// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and stall/bubble/redirect controls back to them.
// master = pipeline side (drives hazard sources), slave = hazard controller.
interface pipe_hazard_ctrl_if;
    logic [4:0]  decode_i_rs1;
    logic [4:0]  decode_i_rs2;
    logic        decode_i_rs1_ren;
    logic        decode_i_rs2_ren;
    logic [4:0]  regE_i_rd;
    logic        regE_i_reg_wen;
    logic        regE_i_is_load;
    logic        fetch_i_valid;
    logic        regM_i_mem_req;
    logic        dcache_i_ready;
    logic        execute_i_mdu_start;
    logic        execute_i_mdu_done;
    logic        execute_i_redirect;
    logic        regF_stall;
    logic        regD_stall;
    logic        regE_stall;
    logic        regM_stall;
    logic        regD_bubble;
    logic        regE_bubble;
    logic        regM_bubble;
    logic        regW_bubble;
    logic        ctrl_o_redirect_fire;
    logic        ctrl_o_timeout;
    logic [31:0] ctrl_o_stall_cycles;

    modport master (
        output decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
               regE_i_rd, regE_i_reg_wen, regE_i_is_load, fetch_i_valid,
               regM_i_mem_req, dcache_i_ready, execute_i_mdu_start,
               execute_i_mdu_done, execute_i_redirect,
        input  regF_stall, regD_stall, regE_stall, regM_stall,
               regD_bubble, regE_bubble, regM_bubble, regW_bubble,
               ctrl_o_redirect_fire, ctrl_o_timeout, ctrl_o_stall_cycles
    );

    modport slave (
        input  decode_i_rs1, decode_i_rs2, decode_i_rs1_ren, decode_i_rs2_ren,
               regE_i_rd, regE_i_reg_wen, regE_i_is_load, fetch_i_valid,
               regM_i_mem_req, dcache_i_ready, execute_i_mdu_start,
               execute_i_mdu_done, execute_i_redirect,
        output regF_stall, regD_stall, regE_stall, regM_stall,
               regD_bubble, regE_bubble, regM_bubble, regW_bubble,
               ctrl_o_redirect_fire, ctrl_o_timeout, ctrl_o_stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble controller for the five-stage pipeline: one hazard class per cycle,
// plus pending-redirect, MDU busy, memory-freeze watchdog and stall counter state.
module pipe_hazard_ctrl #(
    parameter int unsigned WDOG_LIMIT = 255
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [2:0] {
        CLS_RST, CLS_FREEZE, CLS_MDU, CLS_REDIRECT, CLS_LOADUSE, CLS_FETCHWAIT, CLS_RUN
    } hz_class_e;

    localparam logic [7:0] LIMIT = 8'(WDOG_LIMIT);

    hz_class_e   cls;
    logic        mdu_busy;
    logic        redirect_pending;
    logic        timeout;
    logic [7:0]  freeze_cnt;
    logic [31:0] stall_cycles;
    logic        redir_eff;
    logic        load_use;
    logic        f_stall, d_stall, e_stall, m_stall;
    logic        d_bubble, e_bubble, m_bubble, w_bubble, redirect_fire;

    always_comb begin
        redir_eff = hz.execute_i_redirect || redirect_pending;
        load_use  = hz.regE_i_is_load && hz.regE_i_reg_wen && (hz.regE_i_rd != 5'd0) &&
                    ((hz.decode_i_rs1_ren && (hz.decode_i_rs1 == hz.regE_i_rd)) ||
                     (hz.decode_i_rs2_ren && (hz.decode_i_rs2 == hz.regE_i_rd)));
        if (rst)
            cls = CLS_RST;
        else if (hz.regM_i_mem_req && !hz.dcache_i_ready)
            cls = CLS_FREEZE;
        else if ((hz.execute_i_mdu_start || mdu_busy) && !hz.execute_i_mdu_done)
            cls = CLS_MDU;
        else if (redir_eff)
            cls = CLS_REDIRECT;
        else if (load_use)
            cls = CLS_LOADUSE;
        else if (!hz.fetch_i_valid)
            cls = CLS_FETCHWAIT;
        else
            cls = CLS_RUN;
    end

    always_comb begin
        f_stall       = 1'b0;
        d_stall       = 1'b0;
        e_stall       = 1'b0;
        m_stall       = 1'b0;
        d_bubble      = 1'b0;
        e_bubble      = 1'b0;
        m_bubble      = 1'b0;
        w_bubble      = 1'b0;
        redirect_fire = 1'b0;
        case (cls)
            CLS_RST: begin
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                w_bubble = 1'b1;
            end
            CLS_FREEZE: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            CLS_MDU: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_bubble = 1'b1;
            end
            CLS_REDIRECT: begin
                d_bubble      = 1'b1;
                e_bubble      = 1'b1;
                redirect_fire = 1'b1;
            end
            CLS_LOADUSE: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end
            CLS_FETCHWAIT: begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // A redirect arriving while frozen is parked; firing it also absorbs a same-cycle new pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_busy         <= 1'b0;
            redirect_pending <= 1'b0;
            freeze_cnt       <= 8'd0;
            timeout          <= 1'b0;
            stall_cycles     <= 32'd0;
        end else begin
            if (hz.execute_i_mdu_done)
                mdu_busy <= 1'b0;
            else if (hz.execute_i_mdu_start)
                mdu_busy <= 1'b1;

            if (cls == CLS_REDIRECT)
                redirect_pending <= 1'b0;
            else if (redir_eff && (cls == CLS_FREEZE || cls == CLS_MDU))
                redirect_pending <= 1'b1;

            if (cls == CLS_FREEZE) begin
                if (freeze_cnt != LIMIT)
                    freeze_cnt <= freeze_cnt + 8'd1;
                else
                    timeout <= 1'b1;
            end else begin
                freeze_cnt <= 8'd0;
            end

            if (f_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign hz.regF_stall           = f_stall;
    assign hz.regD_stall           = d_stall;
    assign hz.regE_stall           = e_stall;
    assign hz.regM_stall           = m_stall;
    assign hz.regD_bubble          = d_bubble;
    assign hz.regE_bubble          = e_bubble;
    assign hz.regM_bubble          = m_bubble;
    assign hz.regW_bubble          = w_bubble;
    assign hz.ctrl_o_redirect_fire = redirect_fire;
    assign hz.ctrl_o_timeout       = timeout;
    assign hz.ctrl_o_stall_cycles  = stall_cycles;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic,
// checked against a cycle-level reference model of the hazard priority rules.
module tb_pipe_hazard_ctrl;
    localparam int LIMIT = 255;
    localparam int K_RST = 0, K_FREEZE = 1, K_MDU = 2, K_REDIR = 3,
                   K_LU = 4, K_FW = 5, K_RUN = 6;
    // {F,D,E,M stall, D,E,M,W bubble, fire}
    localparam logic [8:0] P_RST   = 9'b0000_1111_0;
    localparam logic [8:0] P_FRZ   = 9'b1111_0001_0;
    localparam logic [8:0] P_MDU   = 9'b1110_0010_0;
    localparam logic [8:0] P_REDIR = 9'b0000_1100_1;
    localparam logic [8:0] P_LU    = 9'b1100_0100_0;
    localparam logic [8:0] P_FW    = 9'b1000_1000_0;
    localparam logic [8:0] P_RUN   = 9'b0000_0000_0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz_if ();
    pipe_hazard_ctrl #(.WDOG_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .hz(hz_if.slave));

    int checks = 0;
    int errors = 0;

    bit          m_busy, m_pend, m_to;
    int          m_fcnt;
    logic [31:0] m_sc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] pattern(input int c);
        case (c)
            K_RST:    return P_RST;
            K_FREEZE: return P_FRZ;
            K_MDU:    return P_MDU;
            K_REDIR:  return P_REDIR;
            K_LU:     return P_LU;
            K_FW:     return P_FW;
            default:  return P_RUN;
        endcase
    endfunction

    function automatic logic [8:0] obs_vec();
        return {hz_if.regF_stall, hz_if.regD_stall, hz_if.regE_stall, hz_if.regM_stall,
                hz_if.regD_bubble, hz_if.regE_bubble, hz_if.regM_bubble, hz_if.regW_bubble,
                hz_if.ctrl_o_redirect_fire};
    endfunction

    function automatic int model_cls();
        bit lu;
        lu = hz_if.regE_i_is_load && hz_if.regE_i_reg_wen && hz_if.regE_i_rd != 0 &&
             ((hz_if.decode_i_rs1_ren && hz_if.decode_i_rs1 == hz_if.regE_i_rd) ||
              (hz_if.decode_i_rs2_ren && hz_if.decode_i_rs2 == hz_if.regE_i_rd));
        if (rst) return K_RST;
        if (hz_if.regM_i_mem_req && !hz_if.dcache_i_ready) return K_FREEZE;
        if ((hz_if.execute_i_mdu_start || m_busy) && !hz_if.execute_i_mdu_done) return K_MDU;
        if (hz_if.execute_i_redirect || m_pend) return K_REDIR;
        if (lu) return K_LU;
        if (!hz_if.fetch_i_valid) return K_FW;
        return K_RUN;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_to = 0; m_fcnt = 0; m_sc = 0;
    endtask

    task automatic model_update(input int c);
        logic [8:0] p;
        p = pattern(c);
        if (c == K_REDIR) m_pend = 0;
        else if ((hz_if.execute_i_redirect || m_pend) && (c == K_FREEZE || c == K_MDU)) m_pend = 1;
        if (hz_if.execute_i_mdu_done) m_busy = 0;
        else if (hz_if.execute_i_mdu_start) m_busy = 1;
        if (c == K_FREEZE) begin
            if (m_fcnt == LIMIT) m_to = 1;
            else m_fcnt = m_fcnt + 1;
        end else begin
            m_fcnt = 0;
        end
        if (p[8] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    endtask

    task automatic set_idle();
        hz_if.decode_i_rs1 = 0; hz_if.decode_i_rs2 = 0;
        hz_if.decode_i_rs1_ren = 0; hz_if.decode_i_rs2_ren = 0;
        hz_if.regE_i_rd = 0; hz_if.regE_i_reg_wen = 0; hz_if.regE_i_is_load = 0;
        hz_if.fetch_i_valid = 1; hz_if.regM_i_mem_req = 0; hz_if.dcache_i_ready = 0;
        hz_if.execute_i_mdu_start = 0; hz_if.execute_i_mdu_done = 0;
        hz_if.execute_i_redirect = 0;
    endtask

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic step(input string tag, input int exp_pat = -1);
        int c;
        #2;
        c = model_cls();
        check_val({tag, "_out"}, 32'(obs_vec()), 32'(pattern(c)));
        if (exp_pat >= 0) check_val({tag, "_pat"}, 32'(obs_vec()), 32'(exp_pat));
        @(posedge clk);
        model_update(c);
        #1;
        check_val({tag, "_to"}, 32'(hz_if.ctrl_o_timeout), 32'(m_to));
        check_val({tag, "_sc"}, hz_if.ctrl_o_stall_cycles, m_sc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        model_reset();
        check_val("rst_out", 32'(obs_vec()), 32'(P_RST));
        check_val("rst_sc", hz_if.ctrl_o_stall_cycles, 32'd0);
        check_val("rst_to", 32'(hz_if.ctrl_o_timeout), 32'd0);
        @(negedge clk);
        rst = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // load-use, then load in Memory, then rd = x0
        hz_if.regE_i_is_load = 1; hz_if.regE_i_reg_wen = 1; hz_if.regE_i_rd = 5;
        hz_if.decode_i_rs1 = 5; hz_if.decode_i_rs1_ren = 1;
        step("lu", P_LU);
        hz_if.regE_i_is_load = 0;
        step("lu_after", P_RUN);
        hz_if.regE_i_is_load = 1; hz_if.regE_i_rd = 0; hz_if.decode_i_rs1 = 0;
        step("lu_x0", P_RUN);
        set_idle();

        // multi-cycle MDU, then single-cycle op
        hz_if.execute_i_mdu_start = 1;
        step("mdu0", P_MDU);
        hz_if.execute_i_mdu_start = 0;
        step("mdu1", P_MDU);
        step("mdu2", P_MDU);
        hz_if.execute_i_mdu_done = 1;
        step("mdu3", P_RUN);
        hz_if.execute_i_mdu_done = 0;
        step("mdu4", P_RUN);
        hz_if.execute_i_mdu_start = 1; hz_if.execute_i_mdu_done = 1;
        step("mdu_1cyc", P_RUN);
        set_idle();
        step("mdu_1cyc_after", P_RUN);

        // redirect masked by freeze fires once, absorbing a fresh pulse
        hz_if.regM_i_mem_req = 1; hz_if.execute_i_redirect = 1;
        step("mredir0", P_FRZ);
        hz_if.execute_i_redirect = 0;
        step("mredir1", P_FRZ);
        hz_if.dcache_i_ready = 1; hz_if.execute_i_redirect = 1;
        step("mredir2", P_REDIR);
        hz_if.execute_i_redirect = 0;
        step("mredir3", P_RUN);
        set_idle();

        // priority: freeze over load-use over fetch wait
        hz_if.regM_i_mem_req = 1; hz_if.fetch_i_valid = 0;
        hz_if.regE_i_is_load = 1; hz_if.regE_i_reg_wen = 1; hz_if.regE_i_rd = 9;
        hz_if.decode_i_rs2 = 9; hz_if.decode_i_rs2_ren = 1;
        step("prio_frz", P_FRZ);
        hz_if.dcache_i_ready = 1;
        step("prio_lu", P_LU);
        hz_if.regE_i_is_load = 0;
        step("prio_fw", P_FW);
        set_idle();

        // reset during MDU busy after 10 stall cycles
        @(negedge clk);
        do_reset();
        hz_if.execute_i_mdu_start = 1;
        step("rmdu", P_MDU);
        hz_if.execute_i_mdu_start = 0;
        for (int i = 1; i < 10; i++) step("rmdu_busy", P_MDU);
        check_val("rmdu_sc10", hz_if.ctrl_o_stall_cycles, 32'd10);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_val("rmdu_rst_out", 32'(obs_vec()), 32'(P_RST));
        check_val("rmdu_rst_sc", hz_if.ctrl_o_stall_cycles, 32'd0);
        @(negedge clk);
        rst = 0;
        step("rmdu_post", P_RUN);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            hz_if.regM_i_mem_req      = ($urandom_range(0, 3) == 0);
            hz_if.dcache_i_ready      = ($urandom_range(0, 1) == 1);
            hz_if.execute_i_mdu_start = ($urandom_range(0, 7) == 0);
            hz_if.execute_i_mdu_done  = ($urandom_range(0, 5) == 0);
            hz_if.execute_i_redirect  = ($urandom_range(0, 7) == 0);
            hz_if.regE_i_is_load      = ($urandom_range(0, 1) == 1);
            hz_if.regE_i_reg_wen      = ($urandom_range(0, 3) != 0);
            hz_if.regE_i_rd           = 5'($urandom_range(0, 7));
            hz_if.decode_i_rs1        = 5'($urandom_range(0, 7));
            hz_if.decode_i_rs2        = 5'($urandom_range(0, 7));
            hz_if.decode_i_rs1_ren    = ($urandom_range(0, 1) == 1);
            hz_if.decode_i_rs2_ren    = ($urandom_range(0, 1) == 1);
            hz_if.fetch_i_valid       = ($urandom_range(0, 3) != 0);
            step("rand");
        end
        set_idle();

        // watchdog: 300 freeze cycles from a clean reset
        @(negedge clk);
        do_reset();
        hz_if.regM_i_mem_req = 1;
        for (int i = 0; i < 300; i++) begin
            step("wdog", P_FRZ);
            check_val("wdog_to_edge", 32'(hz_if.ctrl_o_timeout), (i >= 255) ? 32'd1 : 32'd0);
        end
        check_val("wdog_sc300", hz_if.ctrl_o_stall_cycles, 32'd300);
        set_idle();
        step("wdog_end", P_RUN);
        check_val("wdog_sticky", 32'(hz_if.ctrl_o_timeout), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/bubble controller for the five-stage pipeline. It drives the `stall` and `bubble` inputs of the pipeline registers regF, regD, regE, regM and regW. It resolves four hazard sources: data-cache wait, multi-cycle MDU operations, execute-stage redirects and load-use dependencies. It also holds a pending-redirect flag, MDU busy tracking, a memory-freeze watchdog and a stall performance counter.

## Interface
Parameters:
- `WDOG_LIMIT`, default 255: number of consecutive freeze cycles after which the watchdog fires (8-bit counter).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `decode_i_rs1`, `decode_i_rs2` in 5 each: source register addresses in Decode.
- `decode_i_rs1_ren`, `decode_i_rs2_ren` in 1 each: source read enables.
- `regE_i_rd` in 5: destination register of the instruction in Execute.
- `regE_i_reg_wen` in 1: register write enable of the instruction in Execute.
- `regE_i_is_load` in 1: instruction in Execute is a load.
- `fetch_i_valid` in 1: instruction-fetch data is valid this cycle.
- `regM_i_mem_req` in 1: Memory stage holds a load or store.
- `dcache_i_ready` in 1: data-cache access completes this cycle.
- `execute_i_mdu_start` in 1: one-cycle pulse when a mul/div enters Execute.
- `execute_i_mdu_done` in 1: one-cycle pulse when the MDU result is valid.
- `execute_i_redirect` in 1: one-cycle pulse on a branch mispredict or jump.
- `regF_stall`, `regD_stall`, `regE_stall`, `regM_stall` out 1 each: stall outputs.
- `regD_bubble`, `regE_bubble`, `regM_bubble`, `regW_bubble` out 1 each: bubble outputs.
- `ctrl_o_redirect_fire` out 1: Fetch loads the redirect PC this cycle.
- `ctrl_o_timeout` out 1: sticky watchdog flag.
- `ctrl_o_stall_cycles` out 32: saturating count of cycles with `regF_stall` asserted.

## Operation
Outputs are combinational from the inputs and the state registers. Exactly one hazard class is active per cycle, chosen in priority order (highest first):
1. **RST**: while `rst` is high, all stalls = 0, all bubbles = 1, `redirect_fire` = 0.
2. **FREEZE**, when `regM_i_mem_req && !dcache_i_ready`: F/D/E/M stall = 1, `regW_bubble` = 1.
3. **MDU**, when `(execute_i_mdu_start || mdu_busy) && !execute_i_mdu_done`: F/D/E stall = 1, `regM_bubble` = 1.
4. **REDIRECT**, when `redir_eff = execute_i_redirect || redirect_pending`: `regD_bubble` = `regE_bubble` = 1, `redirect_fire` = 1, `regF_stall` = 0.
5. **LOADUSE**, when `regE_i_is_load && regE_i_reg_wen && regE_i_rd != 0` and a read-enabled Decode source matches `regE_i_rd`: F/D stall = 1, `regE_bubble` = 1.
6. **FETCHWAIT**, when `!fetch_i_valid`: `regF_stall` = 1, `regD_bubble` = 1.
7. **RUN**: all stalls and bubbles = 0.

Outputs not listed for the active class are 0.

State registers (all reset to 0):
- `mdu_busy`:
  - set when `mdu_start && !mdu_done`;
  - cleared when `mdu_done`.
  - `start` and `done` in the same cycle means a single-cycle operation; `mdu_busy` stays 0.
- `redirect_pending`:
  - set when `redir_eff` and the class is FREEZE or MDU;
  - cleared when the REDIRECT class fires.
- `freeze_cnt` (8 bits):
  - increments in each FREEZE cycle, saturating at `WDOG_LIMIT`;
  - cleared in any non-FREEZE cycle.
- `ctrl_o_timeout`:
  - set when FREEZE is active and `freeze_cnt == WDOG_LIMIT`;
  - sticky; cleared only by `rst`.
- `ctrl_o_stall_cycles`:
  - increments by 1 every cycle in which `regF_stall` is 1 (not in RST);
  - saturates at 0xFFFF_FFFF.

## Timing
- Stall and bubble outputs take effect at the same clock edge as the condition that causes them (zero latency). Pipeline registers sample them at that edge.
- A redirect masked by FREEZE or MDU fires in the first cycle the pipeline is no longer frozen. It fires exactly once, even if a new `execute_i_redirect` pulse arrives in that same cycle.
- Load-use costs exactly 1 bubble cycle; the following cycle re-evaluates with the load in Memory.
- Reset in mid-operation clears `mdu_busy`, `redirect_pending`, `freeze_cnt` and `ctrl_o_stall_cycles` immediately (asynchronously). The first cycle after reset deasserts is evaluated as normal.
- Register x0 never causes a load-use stall.

## Test plan
- **Load-use:** E = load with rd = 5, wen = 1; D rs1 = 5, ren = 1 → one cycle of F/D stall plus `regE_bubble`, then RUN. Repeat with rd = 0 → no stall.
- **MDU:** `mdu_start` in cycle 0, `mdu_done` in cycle 3 → F/D/E stall plus `regM_bubble` in cycles 0–2, RUN in cycle 3, `mdu_busy` = 0 afterwards. `start` and `done` in the same cycle → no stall.
- **Masked redirect:** `redirect` pulse in a cycle where `mem_req` = 1 and `dcache_ready` = 0; `ready` rises 2 cycles later → `redirect_fire` and D/E bubble asserted exactly once, in the first non-freeze cycle.
- **Watchdog:** hold FREEZE for 300 cycles → `timeout` = 1 from cycle 256 onward and stays 1 after the freeze ends; `stall_cycles` = 300.
- **Priority:** FREEZE, load-use and `!fetch_valid` all asserted together → only the FREEZE pattern appears. Remove FREEZE → LOADUSE pattern appears.
- **Reset:** assert `rst` during MDU busy with `stall_cycles` = 10 → all bubbles = 1 and stalls = 0 immediately; after release, `stall_cycles` = 0 and `mdu_busy` = 0.
